// File: rtl/traffic_pkg.sv
// Shared phase encoding and default lamp dwell lengths for the traffic-light
// controller and its monitor.
package traffic_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } phase_t;

  localparam int DEF_RED_LEN    = 18;
  localparam int DEF_GREEN_LEN  = 15;
  localparam int DEF_YELLOW_LEN = 3;

  function automatic logic legal_succ(input phase_t from, input phase_t to);
    return (from == RED    && to == GREEN)  ||
           (from == GREEN  && to == YELLOW) ||
           (from == YELLOW && to == RED);
  endfunction

endpackage

// File: rtl/traffic_light_monitor_sat_counter.sv
// Saturating up-counter with clear and load-to-1; clear has priority over
// load, and load has priority over increment.
module sat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load1) begin
      q <= W'(1);
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Observer for the traffic-light lamp outputs: phase order, dwell and dropout.
// Define MON_TRACE_EN to add err_phase/err_dwell capture of the first error.
//
// state  | meaning
// WAIT   | no phase tracked yet (after reset or a dark dropout)
// RED    | red lamp lit
// GREEN  | green lamp lit
// YELLOW | yellow lamp lit
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int RED_LEN    = DEF_RED_LEN,
  parameter int GREEN_LEN  = DEF_GREEN_LEN,
  parameter int YELLOW_LEN = DEF_YELLOW_LEN,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             green,
  input  logic             yellow,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] last_dur,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_dur,
  output logic             err_dark,
  output logic             err_any,
`ifdef MON_TRACE_EN
  output logic [1:0]       err_phase,
  output logic [CNT_W-1:0] err_dwell,
`endif
  output logic [7:0]       cycles_ok
);

  phase_t           ph;
  phase_t           lit_ph;
  logic             partial;
  logic             stuck;
  logic             valid;
  logic             multi;
  logic             dark;
  logic             ev_enter, ev_same, ev_change, ev_drop;
  logic             new_onehot, new_order, new_dur, new_dark, new_any;
  logic             nx_onehot, nx_order, nx_dur, nx_dark;
  logic [CNT_W-1:0] cur_len;

  function automatic logic [CNT_W-1:0] len_of(input phase_t p);
    case (p)
      RED:     return CNT_W'(RED_LEN);
      GREEN:   return CNT_W'(GREEN_LEN);
      YELLOW:  return CNT_W'(YELLOW_LEN);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    lit_ph = WAIT;
    case ({red, green, yellow})
      3'b100:  lit_ph = RED;
      3'b010:  lit_ph = GREEN;
      3'b001:  lit_ph = YELLOW;
      default: lit_ph = WAIT;
    endcase
    multi     = (red & green) | (red & yellow) | (green & yellow);
    dark      = ~(red | green | yellow);
    cur_len   = len_of(ph);
    ev_enter  = !multi && !dark && (ph == WAIT);
    ev_same   = !multi && !dark && (ph != WAIT) && (lit_ph == ph);
    ev_change = !multi && !dark && (ph != WAIT) && (lit_ph != ph);
    ev_drop   = dark && (ph != WAIT);

    new_onehot = multi;
    new_dark   = ev_drop;
    new_order  = ev_change && !legal_succ(ph, lit_ph);
    // A stuck lamp is reported once, as it passes LEN, not again when it ends.
    new_dur    = !partial && !stuck &&
                 ((ev_same && (dwell == cur_len)) ||
                  (ev_change && (dwell != cur_len)));
    new_any    = new_onehot | new_dark | new_order | new_dur;

    nx_onehot = (err_onehot & ~clr_err) | new_onehot;
    nx_order  = (err_order  & ~clr_err) | new_order;
    nx_dur    = (err_dur    & ~clr_err) | new_dur;
    nx_dark   = (err_dark   & ~clr_err) | new_dark;
  end

  sat_counter #(.W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (ev_drop),
    .load1 (ev_enter | ev_change),
    .inc   (ev_same),
    .q     (dwell)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ph         <= WAIT;
      partial    <= 1'b1;
      stuck      <= 1'b0;
      valid      <= 1'b0;
      last_dur   <= '0;
      err_onehot <= 1'b0;
      err_order  <= 1'b0;
      err_dur    <= 1'b0;
      err_dark   <= 1'b0;
      err_any    <= 1'b0;
      cycles_ok  <= '0;
    end else begin
      err_onehot <= nx_onehot;
      err_order  <= nx_order;
      err_dur    <= nx_dur;
      err_dark   <= nx_dark;
      err_any    <= nx_onehot | nx_order | nx_dur | nx_dark;

      if (ev_enter) begin
        ph      <= lit_ph;
        partial <= 1'b1;
        stuck   <= 1'b0;
        valid   <= 1'b0;
      end else if (ev_same) begin
        if (new_dur) begin
          stuck <= 1'b1;
          valid <= 1'b0;
        end
      end else if (ev_change) begin
        ph       <= lit_ph;
        last_dur <= dwell;
        partial  <= 1'b0;
        stuck    <= 1'b0;
        // Errors here belong to the cycle just closed; a RED entry opens a new one.
        valid    <= (lit_ph == RED) ? 1'b1 : (valid & ~(new_order | new_dur));
        if (ph == YELLOW && lit_ph == RED && valid && dwell == cur_len) begin
          cycles_ok <= cycles_ok + 8'd1;
        end
      end else if (ev_drop) begin
        ph      <= WAIT;
        partial <= 1'b1;
        stuck   <= 1'b0;
        valid   <= 1'b0;
      end
    end
  end

  assign phase = ph;

`ifdef MON_TRACE_EN
  logic trc_held;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_phase <= '0;
      err_dwell <= '0;
      trc_held  <= 1'b0;
    end else if (new_any && (!trc_held || clr_err)) begin
      err_phase <= ph;
      err_dwell <= dwell;
      trc_held  <= 1'b1;
    end else if (clr_err) begin
      err_phase <= '0;
      err_dwell <= '0;
      trc_held  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_G = 3'b010;
  localparam logic [2:0] L_Y = 3'b001;
  localparam logic [2:0] L_D = 3'b000;

  logic       clk = 1'b0;
  logic       rst;
  logic       red, green, yellow, clr_err;
  logic [1:0] phase;
  logic [5:0] dwell, last_dur;
  logic       err_onehot, err_order, err_dur, err_dark, err_any;
  logic [7:0] cycles_ok;
`ifdef MON_TRACE_EN
  logic [1:0] err_phase;
  logic [5:0] err_dwell;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .red        (red),
    .green      (green),
    .yellow     (yellow),
    .clr_err    (clr_err),
    .phase      (phase),
    .dwell      (dwell),
    .last_dur   (last_dur),
    .err_onehot (err_onehot),
    .err_order  (err_order),
    .err_dur    (err_dur),
    .err_dark   (err_dark),
    .err_any    (err_any),
`ifdef MON_TRACE_EN
    .err_phase  (err_phase),
    .err_dwell  (err_dwell),
`endif
    .cycles_ok  (cycles_ok)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] l);
    {red, green, yellow} = l;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) step(l);
  endtask

  task automatic check_errs(input string tag, input logic [3:0] exp);
    check(tag, {err_onehot, err_order, err_dur, err_dark}, exp);
  endtask

  initial begin
    rst = 1'b1; clr_err = 1'b0;
    {red, green, yellow} = L_D;
    drive(L_D, 2);
    check("rst_phase", phase, 0);
    check("rst_dwell", dwell, 0);
    check("rst_last", last_dur, 0);
    check_errs("rst_errs", 4'b0000);
    check("rst_any", err_any, 0);
    check("rst_cyc", cycles_ok, 0);
    rst = 1'b0;

    // Two full cycles; the first partial red does not count.
    step(L_R);
    check("enter_phase", phase, 1);
    check("enter_dwell", dwell, 1);
    drive(L_R, 17);
    check("red_dwell18", dwell, 18);
    drive(L_G, 15); drive(L_Y, 3);
    drive(L_R, 18); drive(L_G, 15); drive(L_Y, 3);
    step(L_R);
    check("seq_cyc", cycles_ok, 1);
    check_errs("seq_errs", 4'b0000);
    check("seq_last", last_dur, 3);
    check("seq_dwell", dwell, 1);

    // Stuck green: flagged at the 16th sample, only once.
    drive(L_R, 17);
    drive(L_G, 15);
    check("g15_dur", err_dur, 0);
    step(L_G);
    check("g16_dur", err_dur, 1);
    check("g16_dwell", dwell, 16);
    clr_err = 1'b1; step(L_G); clr_err = 1'b0;
    check("g17_clr", err_dur, 0);
    step(L_Y);
    check("stuck_end_dur", err_dur, 0);
    check("stuck_end_last", last_dur, 17);
    drive(L_Y, 2); step(L_R);
    check("stuck_cyc", cycles_ok, 1);

    // Green straight to red: order error, next good cycle counts.
    drive(L_R, 17); drive(L_G, 15); step(L_R);
    check("order_err", err_order, 1);
    check("order_dur", err_dur, 0);
    check("order_phase", phase, 1);
    drive(L_R, 17); drive(L_G, 15); drive(L_Y, 3); step(L_R);
    check("order_next_cyc", cycles_ok, 2);

    // Illegal encoding at red dwell 5 holds dwell and validity.
    clr_err = 1'b1; step(L_R); clr_err = 1'b0;
    check("clr_any", err_any, 0);
    drive(L_R, 3);
    check("pre_onehot_dwell", dwell, 5);
    step(3'b110);
    check("onehot_err", err_onehot, 1);
    check("onehot_dwell", dwell, 5);
    check("onehot_phase", phase, 1);
    step(L_R);
    check("post_onehot_dwell", dwell, 6);
    drive(L_R, 12); drive(L_G, 15); drive(L_Y, 3); step(L_R);
    check("onehot_cyc", cycles_ok, 3);
    check("onehot_nodur", err_dur, 0);

    // Dark during yellow; next red is a partial phase.
    drive(L_R, 17); drive(L_G, 15); drive(L_Y, 2); step(L_D);
    check("dark_err", err_dark, 1);
    check("dark_phase", phase, 0);
    check("dark_dwell", dwell, 0);
    check("dark_nodur", err_dur, 0);
    drive(L_R, 5); step(L_G);
    check("partial_nodur", err_dur, 0);
    check("partial_last", last_dur, 5);
    check("partial_phase", phase, 2);

    // Short yellow ends in the same cycle clr_err is asserted.
    drive(L_G, 14); drive(L_Y, 2);
    clr_err = 1'b1; step(L_R); clr_err = 1'b0;
    check_errs("clr_race_errs", 4'b0010);
    check("clr_race_any", err_any, 1);
    check("clr_race_cyc", cycles_ok, 3);
`ifdef MON_TRACE_EN
    check("trace_phase", err_phase, 3);
    check("trace_dwell", err_dwell, 2);
`endif

    // Reset mid-phase.
    drive(L_R, 4);
    rst = 1'b1; step(L_R); rst = 1'b0;
    check("midrst_phase", phase, 0);
    check("midrst_cyc", cycles_ok, 0);
    check("midrst_any", err_any, 0);
    drive(L_R, 3); step(L_G);
    check("midrst_partial", err_dur, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
